// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue stage: one-entry holding register gated by a per-register
// pending-write scoreboard, an in-flight writer throttle and a saturating stall counter.
module issue_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int IMM_W        = 16,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic [AW-1:0]    in_src1,
  input  logic [AW-1:0]    in_src2,
  input  logic [AW-1:0]    in_dest,
  input  logic [AW-1:0]    in_cond,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [AW-1:0]    out_src1,
  output logic [AW-1:0]    out_src2,
  output logic [AW-1:0]    out_dest,
  output logic [AW-1:0]    out_cond,
  output logic [IMM_W-1:0] out_imm,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_dest,
  input  logic             flush,
  output logic [3:0]       inflight,
  output logic [15:0]      stall_cycles,
  output logic             wb_err
);

  localparam logic [1:0] T_NOP = 2'b00;
  localparam logic [1:0] T_S   = 2'b01;
  localparam logic [1:0] T_I   = 2'b10;

  logic             hold_valid_q, hold_valid_d;
  logic [1:0]       type_q, type_d;
  logic [AW-1:0]    src1_q, src1_d, src2_q, src2_d, dest_q, dest_d, cond_q, cond_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [3:0]       inflight_q, inflight_d;
  logic [15:0]      stall_q, stall_d;
  logic             wb_err_q, wb_err_d;

  logic [NREG-1:0]  wb_clr_vec, pend_eff;
  logic             wb_hit, wb_bad, writer_h, hazard, issue, accept, issue_wr;

  always_comb begin
    wb_clr_vec = wb_valid ? (NREG'(1) << wb_dest) : '0;
    // a same-cycle writeback already makes the register readable
    pend_eff   = pending_q & ~wb_clr_vec;
    wb_hit     = wb_valid && (wb_dest != '0) && pending_q[wb_dest];
    wb_bad     = wb_valid && (wb_dest != '0) && !pending_q[wb_dest];
    writer_h   = ((type_q == T_S) || (type_q == T_I)) && (dest_q != '0);

    hazard = 1'b0;
    if ((type_q != T_NOP) && (src1_q != '0) && pend_eff[src1_q]) hazard = 1'b1;
    if ((type_q == T_S) && (src2_q != '0) && pend_eff[src2_q])   hazard = 1'b1;
    if (writer_h && pend_eff[dest_q])                             hazard = 1'b1;
    if (writer_h && (inflight_q == 4'(MAX_INFLIGHT)) && !wb_hit)  hazard = 1'b1;

    // execute must never see valid&&ready without the issue taking effect
    out_valid = hold_valid_q && !hazard && !flush;
    issue     = out_valid && out_ready;
    issue_wr  = issue && writer_h;
    in_ready  = (!hold_valid_q || issue) && !flush;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    type_d = type_q;
    src1_d = src1_q;
    src2_d = src2_q;
    dest_d = dest_q;
    cond_d = cond_q;
    imm_d  = imm_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      type_d = in_type;
      src1_d = in_src1;
      src2_d = in_src2;
      dest_d = in_dest;
      cond_d = in_cond;
      imm_d  = in_imm;
    end else if (flush || issue) begin
      hold_valid_d = 1'b0;
    end

    // clear first so that a same-register issue sets the bit back
    pending_d = pending_q;
    if (wb_hit)   pending_d[wb_dest] = 1'b0;
    if (issue_wr) pending_d[dest_q]  = 1'b1;
    pending_d[0] = 1'b0;

    inflight_d = inflight_q;
    if (issue_wr && !wb_hit)      inflight_d = inflight_q + 4'd1;
    else if (!issue_wr && wb_hit) inflight_d = inflight_q - 4'd1;

    stall_d = stall_q;
    if (hold_valid_q && hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;

    wb_err_d = wb_err_q | wb_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      type_q       <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dest_q       <= '0;
      cond_q       <= '0;
      imm_q        <= '0;
      pending_q    <= '0;
      inflight_q   <= '0;
      stall_q      <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      type_q       <= type_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      dest_q       <= dest_d;
      cond_q       <= cond_d;
      imm_q        <= imm_d;
      pending_q    <= pending_d;
      inflight_q   <= inflight_d;
      stall_q      <= stall_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign out_type     = type_q;
  assign out_src1     = src1_q;
  assign out_src2     = src2_q;
  assign out_dest     = dest_q;
  assign out_cond     = cond_q;
  assign out_imm      = imm_q;
  assign inflight     = inflight_q;
  assign stall_cycles = stall_q;
  assign wb_err       = wb_err_q;

endmodule
